gmii_rx_framer: RTL and testbench
=================================

# gmii_rx_framer

Parametrised receive framer on the MAC side of the GMII/RGMII bridge, in the `gmii_rxc` domain. Accepts bytes at 1000 Mb/s or nibbles at 10/100 Mb/s and strips preamble/SFD. Packs payload into `OUT_BYTES`-wide words with keep/last/error sideband and maintains saturating good/bad frame counters. It is the multi-speed, word-packing successor to the plain byte-wide GMII RX path.

## Interface
- `OUT_BYTES`, default 4: output word width in bytes; legal 1..8.
- `CNT_W`, default 16: width of the statistics counters.

- `clk`  in  1  GMII RX clock (`gmii_rxc`).
- `rst`  in  1  asynchronous, active-high reset.
- `speed`  in  2  `2'b10` = 1000 (byte mode); `2'b00`/`2'b01` = 10/100 (nibble mode, `in_d[3:0]`); `2'b11` treated as byte mode.
- `in_dv`  in  1  receive data valid.
- `in_er`  in  1  receive error.
- `in_d`  in  8  receive data.
- `out_valid`  out  1  output beat valid, single-cycle strobe.
- `out_data`  out  8*OUT_BYTES  payload; first received byte in bits [7:0].
- `out_keep`  out  OUT_BYTES  byte enables, contiguous from bit 0.
- `out_last`  out  1  final beat of frame.
- `out_err`  out  1  frame error; valid only with `out_last`.
- `frame_cnt`  out  CNT_W  good frames received, saturating.
- `err_cnt`  out  CNT_W  bad or aborted frames, saturating.

## Operation
- Clocking and reset: one clock, async active-high reset. No backpressure; the consumer must accept every beat.
- Byte assembly:
  - Byte mode: one byte per cycle with `in_dv`=1.
  - Nibble mode: low nibble first, high nibble next. Pairing starts at the first `in_dv`=1 cycle of the frame.
  - `speed` is sampled in IDLE only. Changes mid-frame are ignored until the next IDLE.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - Moves to PREAMBLE on a rising edge of `in_dv`, i.e. registered `dv_q`=0 and `in_dv`=1.
  - `dv_q` resets to 1, so a frame already in flight when reset releases is ignored entirely.
- PREAMBLE:
  - Assembled byte 0x55: stay.
  - 0xD5: go to DATA.
  - Any other byte, or `in_er`=1: go to DROP and increment `err_cnt`.
  - `in_dv` falls before SFD: go to IDLE with no count.
- DATA:
  - Bytes fill the word register in ascending lanes.
  - A full word is held pending. It is emitted with `out_last`=0 when the next byte completes, or with `out_last`=1 when `in_dv` falls.
  - `in_dv` falls with a partial word: emit it with `out_keep` = the filled lanes and `out_last`=1.
  - `in_er`=1 in any DATA cycle sets a sticky error flag, reported on the last beat as `out_err`.
  - Nibble mode, `in_dv` falls after an odd nibble: discard the nibble and set `out_err`.
  - Zero payload bytes (SFD immediately followed by `in_dv`=0): no beat is emitted; `err_cnt` increments.
  - Return to IDLE after the last beat.
- DROP: wait for `in_dv`=0, then go to IDLE. No beats are emitted.
- Counters:
  - `frame_cnt` increments on a beat with `out_last`=1 and `out_err`=0.
  - `err_cnt` increments on a beat with `out_last`=1 and `out_err`=1, on a PREAMBLE abort, and on a zero-payload frame.
  - Both hold at all-ones.
- Unused lanes of `out_data` (keep=0) are driven 0.

## Timing
- Reset values: `out_valid`, `out_last`, `out_err`=0; `out_data`, `out_keep`=0; counters 0; state IDLE.
- Outputs are registered.
- Byte mode latency:
  - A non-last word is emitted in the cycle after the clock edge that samples byte k·OUT_BYTES+1.
  - The last beat is emitted in the cycle after the edge that samples `in_dv`=0.
- Nibble mode: same rules, counted on completed bytes.
- Counter updates are visible in the cycle after the corresponding `out_last` beat.
- A frame whose `in_dv` rises in the cycle right after the previous frame's `in_dv` fall is accepted; the inter-frame gap minimum is 1 cycle.
- `out_valid` is never asserted on two consecutive cycles in nibble mode.
- Reset asserted mid-frame: outputs clear immediately, any partial word is lost, and the rest of that frame is ignored.

## Test plan
- Byte mode, `OUT_BYTES`=4, 7×0x55, 0xD5, then bytes 01..08, then `in_dv`=0:
  - beat 1: `out_data`=0x04030201, keep 0xF, last 0;
  - beat 2: `out_data`=0x08070605, keep 0xF, last 1, err 0;
  - `frame_cnt`=1.
- Byte mode, payload 01..05: second beat `out_data`=0x00000005, keep 0x1, last 1.
- Nibble mode, nibbles 5 ×14, 5, D, then 1,0,2,0,3,0: one beat with `out_data`=0x00030201, keep 0x7, last 1; no two consecutive valids.
- Errors, one frame each:
  - `in_er` pulsed on the 3rd payload byte: last beat has `out_err`=1, `err_cnt`=1, `frame_cnt` unchanged.
  - Preamble byte 0x57: no beats, `err_cnt` increments.
  - Zero-payload frame: no beats, `err_cnt` increments.
- Reset mid-frame:
  - Assert `rst` after 2 payload bytes, release while `in_dv`=1: no beat until `in_dv` falls and a new preamble arrives.
  - The new frame is received normally and the counters restart from 0.
- Saturation: force 2^CNT_W+3 good frames (CNT_W=4 build) -> `frame_cnt` holds at 0xF.

Source files
------------

// File: rtl/gmii_rx_framer.sv
// GMII/RGMII receive framer: strips preamble/SFD in byte or nibble mode and packs
// payload into OUT_BYTES-wide beats with keep/last/err plus saturating frame counters.
module gmii_rx_framer #(
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             speed,
  input  logic                   in_dv,
  input  logic                   in_er,
  input  logic [7:0]             in_d,
  output logic                   out_valid,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   out_err,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int unsigned DW = 8 * OUT_BYTES;
  localparam int unsigned FW = $clog2(OUT_BYTES + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t            state_q, state_n;
  logic              dv_q;
  logic              byte_mode_q, byte_mode_n;
  logic              nib_phase_q, nib_phase_n;
  logic [3:0]        lo_nib_q, lo_nib_n;
  logic [DW-1:0]     word_q, word_n;
  logic [FW-1:0]     fill_q, fill_n;
  logic              err_flag_q, err_flag_n;

  logic              out_valid_n, out_last_n, out_err_n;
  logic [DW-1:0]     out_data_n;
  logic [OUT_BYTES-1:0] out_keep_n;
  logic              abort_c;

  logic              spd_byte_c, byte_mode_c, rise_c, pre_c, byte_done_c;
  logic [7:0]        byte_c;
  logic [OUT_BYTES-1:0] keep_mask_c;
  logic [1:0]        err_inc_c;
  logic [CNT_W:0]    frame_sum_c, err_sum_c;

  assign spd_byte_c  = (speed == 2'b10) || (speed == 2'b11);
  // Speed is only honoured in IDLE; mid-frame the latched mode is used.
  assign byte_mode_c = (state_q == IDLE) ? spd_byte_c : byte_mode_q;
  assign rise_c      = !dv_q && in_dv;
  assign pre_c       = (state_q == PREAMBLE) || ((state_q == IDLE) && rise_c);
  assign byte_done_c = in_dv && (byte_mode_c || nib_phase_q);
  assign byte_c      = byte_mode_c ? in_d : {in_d[3:0], lo_nib_q};

  always_comb begin
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      keep_mask_c[i] = (FW'(i) < fill_q);
    end
  end

  // Next-state, word assembly and output beat generation
  always_comb begin
    state_n     = state_q;
    byte_mode_n = byte_mode_q;
    nib_phase_n = nib_phase_q;
    lo_nib_n    = lo_nib_q;
    word_n      = word_q;
    fill_n      = fill_q;
    err_flag_n  = err_flag_q;
    out_valid_n = 1'b0;
    out_data_n  = '0;
    out_keep_n  = '0;
    out_last_n  = 1'b0;
    out_err_n   = 1'b0;
    abort_c     = 1'b0;

    if (state_q == IDLE) begin
      byte_mode_n = spd_byte_c;
    end

    if ((pre_c || (state_q == DATA)) && in_dv && !byte_mode_c) begin
      if (!nib_phase_q) begin
        lo_nib_n    = in_d[3:0];
        nib_phase_n = 1'b1;
      end else begin
        nib_phase_n = 1'b0;
      end
    end

    if (pre_c) begin
      if (!in_dv) begin
        state_n = IDLE;
      end else if (in_er) begin
        state_n = DROP;
        abort_c = 1'b1;
      end else if (byte_done_c) begin
        if (byte_c == 8'h55) begin
          state_n = PREAMBLE;
        end else if (byte_c == 8'hD5) begin
          state_n    = DATA;
          word_n     = '0;
          fill_n     = '0;
          err_flag_n = 1'b0;
        end else begin
          state_n = DROP;
          abort_c = 1'b1;
        end
      end else begin
        state_n = PREAMBLE;
      end
    end else begin
      case (state_q)
        DATA: begin
          if (!in_dv) begin
            state_n = IDLE;
            if (fill_q == '0) begin
              abort_c = 1'b1;
            end else begin
              out_valid_n = 1'b1;
              out_data_n  = word_q;
              out_keep_n  = keep_mask_c;
              out_last_n  = 1'b1;
              out_err_n   = err_flag_q || in_er || nib_phase_q;
            end
          end else begin
            if (in_er) err_flag_n = 1'b1;
            if (byte_done_c) begin
              if (fill_q == FW'(OUT_BYTES)) begin
                out_valid_n = 1'b1;
                out_data_n  = word_q;
                out_keep_n  = '1;
                word_n      = DW'(byte_c);
                fill_n      = FW'(1);
              end else begin
                for (int unsigned i = 0; i < OUT_BYTES; i++) begin
                  if (fill_q == FW'(i)) word_n[8*i +: 8] = byte_c;
                end
                fill_n = fill_q + FW'(1);
              end
            end
          end
        end
        DROP: begin
          if (!in_dv) state_n = IDLE;
        end
        default: ;
      endcase
    end

    if ((state_n == IDLE) || (state_n == DROP)) begin
      nib_phase_n = 1'b0;
    end
  end

  assign err_inc_c   = 2'(out_valid && out_last && out_err) + 2'(abort_c);
  assign frame_sum_c = {1'b0, frame_cnt} + (CNT_W+1)'(out_valid && out_last && !out_err);
  assign err_sum_c   = {1'b0, err_cnt} + (CNT_W+1)'(err_inc_c);

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dv_q        <= 1'b1;
      byte_mode_q <= 1'b1;
      nib_phase_q <= 1'b0;
      lo_nib_q    <= '0;
      word_q      <= '0;
      fill_q      <= '0;
      err_flag_q  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
      out_last    <= 1'b0;
      out_err     <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_n;
      dv_q        <= in_dv;
      byte_mode_q <= byte_mode_n;
      nib_phase_q <= nib_phase_n;
      lo_nib_q    <= lo_nib_n;
      word_q      <= word_n;
      fill_q      <= fill_n;
      err_flag_q  <= err_flag_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_keep    <= out_keep_n;
      out_last    <= out_last_n;
      out_err     <= out_err_n;
      frame_cnt   <= frame_sum_c[CNT_W] ? '1 : frame_sum_c[CNT_W-1:0];
      err_cnt     <= err_sum_c[CNT_W]   ? '1 : err_sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: byte/nibble framing, errors, reset and counter saturation.
module tb_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  speed;
  logic        in_dv, in_er;
  logic [7:0]  in_d;

  logic        out_valid, out_last, out_err;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] frame_cnt, err_cnt;

  logic        s_valid, s_last, s_err;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [3:0]  s_frame_cnt, s_err_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] bq_data[$];
  logic [3:0]  bq_keep[$];
  logic        bq_last[$];
  logic        bq_err[$];
  logic        prev_v = 1'b0;
  logic        back_to_back_v = 1'b0;

  logic [7:0]  pl[0:31];
  logic [3:0]  nb[0:63];

  always #5 clk = ~clk;

  gmii_rx_framer #(.OUT_BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .speed(speed), .in_dv(in_dv), .in_er(in_er), .in_d(in_d),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_err(out_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  gmii_rx_framer #(.OUT_BYTES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .speed(speed), .in_dv(in_dv), .in_er(in_er), .in_d(in_d),
    .out_valid(s_valid), .out_data(s_data), .out_keep(s_keep), .out_last(s_last),
    .out_err(s_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  // Beat recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      bq_data.push_back(out_data);
      bq_keep.push_back(out_keep);
      bq_last.push_back(out_last);
      bq_err.push_back(out_err);
      if (prev_v) back_to_back_v = 1'b1;
    end
    prev_v = out_valid && !rst;
  end

  task automatic clear_log();
    bq_data.delete(); bq_keep.delete(); bq_last.delete(); bq_err.delete();
    back_to_back_v = 1'b0;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk); #1;
    in_dv = dv; in_d = d; in_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Byte-mode frame: npre x 0x55, SFD, pl[0..n-1], then in_dv low (er_at = payload index with in_er)
  task automatic send_frame(input int npre, input int n, input int er_at, input int gap);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) drive(1'b1, pl[i], (i == er_at));
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_nibbles(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, {4'h0, nb[i]}, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; speed = 2'b10; in_dv = 1'b0; in_er = 1'b0; in_d = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0 || out_keep !== 4'h0) begin failures++; $display("FAIL reset_data got=%h/%h want=0/0", out_data, out_keep); end
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", frame_cnt, err_cnt); end
  endtask

  task automatic test_byte_full();
    clear_log();
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_frame(7, 8, -1, 4);
    checks++; if (bq_data.size() !== 2) begin failures++; $display("FAIL full_beats got=%0d want=2", bq_data.size()); end
    else begin
      checks++; if (bq_data[0] !== 32'h04030201 || bq_keep[0] !== 4'hF || bq_last[0] !== 1'b0)
        begin failures++; $display("FAIL full_beat1 got=%h/%h/%b want=04030201/f/0", bq_data[0], bq_keep[0], bq_last[0]); end
      checks++; if (bq_data[1] !== 32'h08070605 || bq_keep[1] !== 4'hF || bq_last[1] !== 1'b1 || bq_err[1] !== 1'b0)
        begin failures++; $display("FAIL full_beat2 got=%h/%h/%b/%b want=08070605/f/1/0", bq_data[1], bq_keep[1], bq_last[1], bq_err[1]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL full_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_byte_partial();
    clear_log();
    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    send_frame(7, 5, -1, 4);
    checks++; if (bq_data.size() !== 2) begin failures++; $display("FAIL partial_beats got=%0d want=2", bq_data.size()); end
    else begin
      checks++; if (bq_data[1] !== 32'h00000005 || bq_keep[1] !== 4'h1 || bq_last[1] !== 1'b1)
        begin failures++; $display("FAIL partial_last got=%h/%h/%b want=00000005/1/1", bq_data[1], bq_keep[1], bq_last[1]); end
    end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL partial_frame_cnt got=%0d want=2", frame_cnt); end
  endtask

  task automatic test_nibble();
    clear_log();
    speed = 2'b00;
    idle(2);
    for (int i = 0; i < 14; i++) nb[i] = 4'h5;
    nb[14] = 4'h5; nb[15] = 4'hD;
    nb[16] = 4'h1; nb[17] = 4'h0; nb[18] = 4'h2; nb[19] = 4'h0; nb[20] = 4'h3; nb[21] = 4'h0;
    send_nibbles(22);
    idle(4);
    checks++; if (bq_data.size() !== 1) begin failures++; $display("FAIL nib_beats got=%0d want=1", bq_data.size()); end
    else begin
      checks++; if (bq_data[0] !== 32'h00030201 || bq_keep[0] !== 4'h7 || bq_last[0] !== 1'b1 || bq_err[0] !== 1'b0)
        begin failures++; $display("FAIL nib_beat got=%h/%h/%b/%b want=00030201/7/1/0", bq_data[0], bq_keep[0], bq_last[0], bq_err[0]); end
    end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL nib_frame_cnt got=%0d want=3", frame_cnt); end
  endtask

  task automatic test_odd_nibble();
    clear_log();
    nb[0] = 4'h5; nb[1] = 4'h5; nb[2] = 4'h5; nb[3] = 4'hD;
    nb[4] = 4'h1; nb[5] = 4'h0; nb[6] = 4'h2;
    send_nibbles(7);
    idle(4);
    checks++; if (bq_data.size() !== 1) begin failures++; $display("FAIL odd_beats got=%0d want=1", bq_data.size()); end
    else begin
      checks++; if (bq_data[0] !== 32'h00000001 || bq_keep[0] !== 4'h1 || bq_err[0] !== 1'b1)
        begin failures++; $display("FAIL odd_beat got=%h/%h/%b want=00000001/1/1", bq_data[0], bq_keep[0], bq_err[0]); end
    end
    checks++; if (back_to_back_v !== 1'b0) begin failures++; $display("FAIL nib_consecutive_valid got=1 want=0"); end
    checks++; if (err_cnt !== 16'd1 || frame_cnt !== 16'd3) begin failures++; $display("FAIL odd_cnt got=%0d/%0d want=3/1", frame_cnt, err_cnt); end
    speed = 2'b10;
    idle(2);
  endtask

  task automatic test_data_error();
    clear_log();
    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    send_frame(7, 5, 2, 4);
    checks++; if (bq_data.size() !== 2) begin failures++; $display("FAIL derr_beats got=%0d want=2", bq_data.size()); end
    else begin
      checks++; if (bq_err[1] !== 1'b1 || bq_last[1] !== 1'b1) begin failures++; $display("FAIL derr_last got=err%b/last%b want=1/1", bq_err[1], bq_last[1]); end
    end
    checks++; if (err_cnt !== 16'd2 || frame_cnt !== 16'd3) begin failures++; $display("FAIL derr_cnt got=%0d/%0d want=3/2", frame_cnt, err_cnt); end
  endtask

  task automatic test_preamble_error();
    clear_log();
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h57, 1'b0);
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h01, 1'b0); drive(1'b1, 8'h02, 1'b0);
    idle(4);
    checks++; if (bq_data.size() !== 0) begin failures++; $display("FAIL pre_beats got=%0d want=0", bq_data.size()); end
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL pre_err_cnt got=%0d want=3", err_cnt); end
  endtask

  task automatic test_zero_payload();
    clear_log();
    send_frame(7, 0, -1, 4);
    checks++; if (bq_data.size() !== 0) begin failures++; $display("FAIL zero_beats got=%0d want=0", bq_data.size()); end
    checks++; if (err_cnt !== 16'd4 || frame_cnt !== 16'd3) begin failures++; $display("FAIL zero_cnt got=%0d/%0d want=3/4", frame_cnt, err_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    for (int i = 0; i < 4; i++) pl[i] = 8'(i + 1);
    send_frame(2, 4, -1, 0);
    for (int i = 0; i < 4; i++) pl[i] = 8'(8'h11 + i);
    send_frame(2, 4, -1, 4);
    checks++; if (bq_data.size() !== 2) begin failures++; $display("FAIL b2b_beats got=%0d want=2", bq_data.size()); end
    else begin
      checks++; if (bq_data[0] !== 32'h04030201 || bq_last[0] !== 1'b1 || bq_keep[0] !== 4'hF)
        begin failures++; $display("FAIL b2b_beat1 got=%h/%h/%b want=04030201/f/1", bq_data[0], bq_keep[0], bq_last[0]); end
      checks++; if (bq_data[1] !== 32'h14131211 || bq_last[1] !== 1'b1)
        begin failures++; $display("FAIL b2b_beat2 got=%h/%b want=14131211/1", bq_data[1], bq_last[1]); end
    end
    checks++; if (frame_cnt !== 16'd5) begin failures++; $display("FAIL b2b_frame_cnt got=%0d want=5", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h01, 1'b0); drive(1'b1, 8'h02, 1'b0);
    @(posedge clk); #1; rst = 1'b1; in_d = 8'h03;
    #1;
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL rst_async got=%0d/%0d/%b want=0/0/0", frame_cnt, err_cnt, out_valid); end
    drive(1'b1, 8'h04, 1'b0);
    @(posedge clk); #1; rst = 1'b0; in_d = 8'h05;
    drive(1'b1, 8'h06, 1'b0); drive(1'b1, 8'h07, 1'b0); drive(1'b1, 8'h08, 1'b0);
    idle(5);
    checks++; if (bq_data.size() !== 0) begin failures++; $display("FAIL rst_ignored_beats got=%0d want=0", bq_data.size()); end
    checks++; if (err_cnt !== 16'd0 || frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_ignored_cnt got=%0d/%0d want=0/0", frame_cnt, err_cnt); end
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_frame(7, 8, -1, 4);
    checks++; if (bq_data.size() !== 2) begin failures++; $display("FAIL rst_new_beats got=%0d want=2", bq_data.size()); end
    else begin
      checks++; if (bq_data[1] !== 32'h08070605 || bq_last[1] !== 1'b1)
        begin failures++; $display("FAIL rst_new_beat2 got=%h/%b want=08070605/1", bq_data[1], bq_last[1]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL rst_new_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_saturation();
    pl[0] = 8'hAA;
    for (int f = 0; f < 13; f++) send_frame(1, 1, -1, 1);
    idle(2);
    checks++; if (s_frame_cnt !== 4'hE) begin failures++; $display("FAIL sat_pre got=%h want=e", s_frame_cnt); end
    for (int f = 0; f < 6; f++) send_frame(1, 1, -1, 1);
    idle(2);
    checks++; if (s_frame_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%h want=f", s_frame_cnt); end
    checks++; if (frame_cnt !== 16'd20) begin failures++; $display("FAIL sat_wide got=%0d want=20", frame_cnt); end
    checks++; if (s_err_cnt !== 4'h0) begin failures++; $display("FAIL sat_err_cnt got=%h want=0", s_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_byte_full();
    test_byte_partial();
    test_nibble();
    test_odd_nibble();
    test_data_error();
    test_preamble_error();
    test_zero_payload();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
